ty_stream_join_fifo: RTL and testbench
======================================

// Module: ty_stream_join_fifo
// PURPOSE
//  Input-side stage placed directly upstream of the kernel top wrapper.
//  Buffers each AXI-stream input channel in its own small FIFO so producers run skewed and independent.
//  Presents all channels valid together, so the kernel's all-valid join never deadlocks a producer.
//  Pops every channel in lock-step on each joined beat and counts joined beats.
// PARAMETERS
//  C_DATA_WIDTH    32*TY_GVECT  packed vector width per channel (32..512)
//  C_NUM_CHANNELS  2            number of input channels (>=1)
//  C_FIFO_DEPTH    4            entries per channel FIFO; power of two, >=2
// PORTS
//  aclk      in   1                 clock, all logic rising-edge
//  areset    in   1                 asynchronous reset, active-low (0 = reset)
//  s_tvalid  in   [NCH]             per-channel producer data valid
//  s_tdata   in   [NCH][W]          per-channel producer data
//  s_tready  out  [NCH]             per-channel FIFO not full
//  m_tvalid  out  [NCH]             joined valid, all bits identical
//  m_tdata   out  [NCH][W]          head entry of each channel FIFO
//  m_tready  in   [NCH]             kernel back-pressure; pop only when all bits set
//  beat_cnt  out  32                joined beats since reset; wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset (areset=0, async assert, sync deassert at kernel level):
//   - all ptrs, counts and beat_cnt = 0
//   - s_tready = 0 while in reset; = 1 from first edge after release
//   - m_tvalid = 0; m_tdata = 0
//  Per-channel FIFO i:
//   - push_i = s_tvalid[i] & s_tready[i]
//   - s_tready[i] = (count_i != C_FIFO_DEPTH); registered-state only, no comb path from m_tready
//   - full FIFO stays not-ready even if a pop occurs that cycle; ready returns next cycle
//   - count width $clog2(DEPTH)+1; wr/rd ptrs $clog2(DEPTH) bits, natural wrap
//  Join:
//   - join_valid = AND over i of (count_i != 0); m_tvalid = {NCH{join_valid}}
//   - pop = join_valid & (&m_tready); pop applies to every channel in the same cycle
//   - m_tdata[i] = mem_i[rd_ptr_i], read combinationally from the register array; 0 when count_i==0
//   - simultaneous push & pop on a channel: count unchanged, both ptrs advance
//  Latency: push in cycle N -> visible on m_tdata/m_tvalid in N+1 (if other channels non-empty).
//  Throughput: 1 joined beat/cycle sustained when all producers and kernel stream continuously.
//  Ordering: strict FIFO per channel; beat k of every channel is delivered together.
//  AXI rules:
//   - m_tvalid never deasserts without a pop
//   - m_tdata is stable while m_tvalid=1 & no pop
//  beat_cnt increments by 1 on every pop.
//  Reset mid-operation: all buffered data discarded; no partial beat emitted after release.
// STRUCTURE
//  Package ty_stream_pkg:
//   - TY_GVECT-derived C_DATA_WIDTH constant
//   - typedef vec_t = logic [C_DATA_WIDTH-1:0]
//   - clog2-based ptr/count width helpers
//  Sub-module ty_sync_fifo (one per channel, generate loop):
//   - ports push/pop/din/dout/count/full/empty
//  Top holds only:
//   - the join AND
//   - pop fan-out
//   - beat_cnt
// TESTING
//  1. Reset: hold areset=0 with s_tvalid=2'b11 -> s_tready=0, m_tvalid=0, beat_cnt=0 throughout.
//  2. Skew: ch0 pushes 0xA0..0xA3 at cycles 1-4, ch1 pushes 0xB0..0xB3 at cycles 5-8, m_tready=2'b11
//     -> 4 beats {A0,B0}..{A3,B3} in order; first m_tvalid at cycle 6; beat_cnt=4.
//  3. Full: m_tready=0, ch0 drives 5 beats
//     -> s_tready[0] falls after 4th push; 5th held; no data lost once m_tready=1.
//  4. Streaming: both channels continuous, m_tready=1 for 100 cycles
//     -> 1 beat/cycle after 1-cycle fill latency; beat_cnt=99 or 100 per latency.
//  5. Partial ready: m_tready=2'b01 with both FIFOs non-empty
//     -> no pop, m_tdata stable, counts unchanged.
//  6. Mid-op reset: assert areset=0 with 3 entries queued
//     -> outputs cleared immediately (async); after release, FIFOs empty, beat_cnt=0.
//  Also: beat_cnt forced to 0xFFFFFFFF via force/release, one pop -> 0.

Source files
------------

// File: rtl/ty_stream_pkg.sv
// Shared constants and width helpers for the stream join FIFO and its channel FIFOs.
package ty_stream_pkg;

  localparam int TY_GVECT      = 1;
  localparam int TY_DATA_WIDTH = 32 * TY_GVECT;

  typedef logic [TY_DATA_WIDTH-1:0] vec_t;

  // A one-entry-wide pointer is still kept at one bit so the FIFO never has a zero-width field.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ty_sync_fifo.sv
// Single-clock FIFO for one input channel; head entry is visible combinationally on dout.
module ty_sync_fifo
  import ty_stream_pkg::*;
#(
  parameter int W     = TY_DATA_WIDTH,
  parameter int DEPTH = 4,
  localparam int PW   = ptr_w(DEPTH),
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          live_q;
  logic          push_ok;
  logic          pop_ok;

  // Not accepting while in reset or until the first edge after release, so full covers both.
  assign full    = ~live_q | (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign count   = count_q;
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      live_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      live_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/ty_stream_join_fifo.sv
// Per-channel input buffering with an all-channels-valid join and a joined-beat counter.
module ty_stream_join_fifo
  import ty_stream_pkg::*;
#(
  parameter int C_DATA_WIDTH   = TY_DATA_WIDTH,
  parameter int C_NUM_CHANNELS = 2,
  parameter int C_FIFO_DEPTH   = 4
) (
  input  logic                                     aclk,
  input  logic                                     areset,
  input  logic [C_NUM_CHANNELS-1:0]                s_tvalid,
  input  logic [C_NUM_CHANNELS*C_DATA_WIDTH-1:0]   s_tdata,
  output logic [C_NUM_CHANNELS-1:0]                s_tready,
  output logic [C_NUM_CHANNELS-1:0]                m_tvalid,
  output logic [C_NUM_CHANNELS*C_DATA_WIDTH-1:0]   m_tdata,
  input  logic [C_NUM_CHANNELS-1:0]                m_tready,
  output logic [31:0]                              beat_cnt
);

  localparam int CW = cnt_w(C_FIFO_DEPTH);

  logic [C_NUM_CHANNELS-1:0] chan_ok;
  logic                      join_valid;
  logic                      pop;
  logic [31:0]               beat_cnt_q, beat_cnt_d;

  for (genvar gi = 0; gi < C_NUM_CHANNELS; gi++) begin : g_ch
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    ty_sync_fifo #(
      .W     (C_DATA_WIDTH),
      .DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
      .clk   (aclk),
      .rst_n (areset),
      .push  (s_tvalid[gi]),
      .pop   (pop),
      .din   (s_tdata[gi*C_DATA_WIDTH +: C_DATA_WIDTH]),
      .dout  (m_tdata[gi*C_DATA_WIDTH +: C_DATA_WIDTH]),
      .count (count),
      .full  (full),
      .empty (empty)
    );

    assign chan_ok[gi]  = (count != '0) & ~empty;
    assign s_tready[gi] = ~full;
  end

  // Every channel pops together, so a beat is only released once all heads exist.
  assign join_valid = &chan_ok;
  assign pop        = join_valid & (&m_tready);
  assign m_tvalid   = {C_NUM_CHANNELS{join_valid}};
  assign beat_cnt   = beat_cnt_q;

  always_comb begin
    beat_cnt_d = beat_cnt_q + 32'(pop);
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_ty_stream_join_fifo.sv
// Bench for ty_stream_join_fifo: queue-based reference model checked every cycle plus directed literal checks.
module tb_ty_stream_join_fifo;

  localparam int NCH   = 2;
  localparam int W     = 32;
  localparam int DEPTH = 4;

  logic              aclk = 1'b0;
  logic              areset = 1'b0;
  logic [NCH-1:0]    s_tvalid;
  logic [NCH*W-1:0]  s_tdata;
  logic [NCH-1:0]    s_tready;
  logic [NCH-1:0]    m_tvalid;
  logic [NCH*W-1:0]  m_tdata;
  logic [NCH-1:0]    m_tready;
  logic [31:0]       beat_cnt;

  int checks = 0;
  int failures = 0;

  ty_stream_join_fifo #(
    .C_DATA_WIDTH   (W),
    .C_NUM_CHANNELS (NCH),
    .C_FIFO_DEPTH   (DEPTH)
  ) dut (
    .aclk     (aclk),
    .areset   (areset),
    .s_tvalid (s_tvalid),
    .s_tdata  (s_tdata),
    .s_tready (s_tready),
    .m_tvalid (m_tvalid),
    .m_tdata  (m_tdata),
    .m_tready (m_tready),
    .beat_cnt (beat_cnt)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per channel, a "live since reset" flag and a beat counter.
  logic [31:0] mq0[$];
  logic [31:0] mq1[$];
  bit          m_live;
  logic [31:0] m_cnt;
  bit          r0, r1, pp;

  always @(posedge aclk or negedge areset) begin
    if (!areset) begin
      mq0.delete();
      mq1.delete();
      m_live = 1'b0;
      m_cnt  = '0;
    end else begin
      r0 = m_live && (mq0.size() < DEPTH);
      r1 = m_live && (mq1.size() < DEPTH);
      pp = (mq0.size() > 0) && (mq1.size() > 0) && (&m_tready);
      if (pp) begin
        void'(mq0.pop_front());
        void'(mq1.pop_front());
        m_cnt = m_cnt + 32'd1;
      end
      if (s_tvalid[0] && r0) mq0.push_back(s_tdata[31:0]);
      if (s_tvalid[1] && r1) mq1.push_back(s_tdata[63:32]);
      m_live = 1'b1;
    end
  end

  logic [31:0] cap0[$];
  logic [31:0] cap1[$];

  always @(negedge aclk) begin
    logic [1:0]  e_rdy;
    logic [1:0]  e_vld;
    logic [63:0] e_dat;
    e_rdy = {m_live && (mq1.size() < DEPTH), m_live && (mq0.size() < DEPTH)};
    e_vld = ((mq0.size() > 0) && (mq1.size() > 0)) ? 2'b11 : 2'b00;
    e_dat = {(mq1.size() > 0) ? mq1[0] : 32'h0, (mq0.size() > 0) ? mq0[0] : 32'h0};
    chk("s_tready", 64'(s_tready), 64'(e_rdy));
    chk("m_tvalid", 64'(m_tvalid), 64'(e_vld));
    chk("m_tdata", m_tdata, e_dat);
    chk("beat_cnt", 64'(beat_cnt), 64'(m_cnt));
    if (m_tvalid == 2'b11 && m_tready == 2'b11) begin
      cap0.push_back(m_tdata[31:0]);
      cap1.push_back(m_tdata[63:32]);
      $display("beat cnt=%0d ch0=%h ch1=%h", beat_cnt, m_tdata[31:0], m_tdata[63:32]);
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int first_vld;
    int idx0, idx1;
    logic [1:0]  rdy;
    logic [63:0] hold_d;
    logic [31:0] hold_b;

    s_tvalid = '0;
    s_tdata  = '0;
    m_tready = '0;

    // 1. Reset held with producers valid.
    areset   = 1'b0;
    s_tvalid = 2'b11;
    s_tdata  = {32'h1111_1111, 32'h2222_2222};
    repeat (4) begin
      step();
      chk("rst_s_tready", 64'(s_tready), 64'(2'b00));
      chk("rst_m_tvalid", 64'(m_tvalid), 64'(2'b00));
      chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    end
    areset   = 1'b1;
    s_tvalid = '0;
    step();
    chk("rel_s_tready", 64'(s_tready), 64'(2'b11));

    // 2. Skewed producers.
    cap0.delete(); cap1.delete();
    first_vld = 0;
    m_tready  = 2'b11;
    for (int c = 1; c <= 12; c++) begin
      if (first_vld == 0 && m_tvalid == 2'b11) first_vld = c;
      s_tvalid[0] = (c <= 4);
      s_tvalid[1] = (c >= 5 && c <= 8);
      s_tdata[31:0]  = 32'hA0 + 32'(c - 1);
      s_tdata[63:32] = 32'hB0 + 32'(c - 5);
      step();
    end
    s_tvalid = '0;
    chk("skew_first_valid", 64'(first_vld), 64'd6);
    chk("skew_beat_cnt", 64'(beat_cnt), 64'd4);
    chk("skew_nbeats", 64'(cap0.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk("skew_ch0", 64'(cap0[k]), 64'(32'hA0 + k));
      chk("skew_ch1", 64'(cap1[k]), 64'(32'hB0 + k));
    end

    // 3. Fill to full under back-pressure, then drain.
    cap0.delete(); cap1.delete();
    m_tready = 2'b00;
    idx0 = 0; idx1 = 0;
    for (int c = 0; c < 18; c++) begin
      if (c == 8) begin
        chk("full_pushes", 64'(idx0), 64'd4);
        chk("full_s_tready0", 64'(s_tready[0]), 64'd0);
        m_tready = 2'b11;
      end
      s_tvalid[0] = (idx0 < 5);
      s_tvalid[1] = (idx1 < 5);
      s_tdata[31:0]  = 32'hC0 + 32'(idx0);
      s_tdata[63:32] = 32'hD0 + 32'(idx1);
      rdy = s_tready;
      step();
      if (rdy[0] && s_tvalid[0]) idx0++;
      if (rdy[1] && s_tvalid[1]) idx1++;
    end
    s_tvalid = '0;
    repeat (3) step();
    chk("full_nbeats", 64'(cap0.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      chk("full_ch0", 64'(cap0[k]), 64'(32'hC0 + k));
      chk("full_ch1", 64'(cap1[k]), 64'(32'hD0 + k));
    end
    chk("full_beat_cnt", 64'(beat_cnt), 64'd9);

    // 4. Continuous streaming from a fresh reset.
    areset = 1'b0;
    step();
    areset = 1'b1;
    step();
    m_tready = 2'b11;
    for (int c = 1; c <= 100; c++) begin
      s_tvalid = 2'b11;
      s_tdata  = {32'h2000 + 32'(c), 32'h1000 + 32'(c)};
      step();
    end
    s_tvalid = '0;
    chk("stream_beat_cnt", 64'(beat_cnt), 64'd99);
    chk("stream_head", m_tdata, {32'h2064, 32'h1064});

    // 5. Partial ready: no pop, data held.
    m_tready = 2'b01;
    hold_d = m_tdata;
    hold_b = beat_cnt;
    repeat (5) step();
    chk("part_m_tdata", m_tdata, hold_d);
    chk("part_beat_cnt", 64'(beat_cnt), 64'(hold_b));
    chk("part_m_tvalid", 64'(m_tvalid), 64'(2'b11));

    // 6. Reset with three entries queued per channel.
    for (int c = 0; c < 2; c++) begin
      s_tvalid = 2'b11;
      s_tdata  = {32'h3000 + 32'(c), 32'h4000 + 32'(c)};
      step();
    end
    s_tvalid = '0;
    #2;
    areset = 1'b0;
    #1;
    chk("midrst_m_tvalid", 64'(m_tvalid), 64'(2'b00));
    chk("midrst_s_tready", 64'(s_tready), 64'(2'b00));
    chk("midrst_m_tdata", m_tdata, 64'h0);
    chk("midrst_beat_cnt", 64'(beat_cnt), 64'd0);
    step();
    areset = 1'b1;
    step();
    chk("post_m_tvalid", 64'(m_tvalid), 64'(2'b00));
    chk("post_beat_cnt", 64'(beat_cnt), 64'd0);
    chk("post_s_tready", 64'(s_tready), 64'(2'b11));

    // 7. Counter wrap.
    m_tready = 2'b11;
    force dut.beat_cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.beat_cnt_q;
    chk("wrap_forced", 64'(beat_cnt), 64'hFFFF_FFFF);
    s_tvalid = 2'b11;
    s_tdata  = {32'h5555_0001, 32'h6666_0001};
    step();
    s_tvalid = '0;
    step();
    chk("wrap_beat_cnt", 64'(beat_cnt), 64'd0);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
